// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID latch: owns the PC, next-PC priority, redirect bubbles and interrupt entry.
// Redirect to IF_PC takes one cycle; Stall holds the PC and the latch, but a taken branch still overrides it.
module if_stage #(
    parameter logic [31:0] RESET_PC   = 32'h80000000,
    parameter logic [31:0] IRQ_VECTOR = 32'h80000004,
    parameter logic [31:0] EXC_VECTOR = 32'h80000008
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Branch_taken,
    input  logic [31:0] Branch_target,
    input  logic [2:0]  ID_PCSrc,
    input  logic [31:0] Jump_target,
    input  logic [31:0] Jr_target,
    input  logic        IRQ,
    input  logic [31:0] IF_Instruction,
    output logic [31:0] IF_PC,
    output logic [31:0] IF_PC_plus_4,
    output logic [31:0] ID_Instruction,
    output logic [31:0] ID_PC_plus_4,
    output logic        Flush_IF_and_ID,
    output logic        IRQ_Taken,
    output logic [31:0] EPC
);

    logic        irq_q;
    logic        irq_pending;
    logic        redirect_code;
    logic        take_irq;
    logic        bubble;
    logic [31:0] next_pc;
    logic        unused_jump_msb;

    // Jumps never change privilege, so the target's top bit is not used.
    assign unused_jump_msb = Jump_target[31];

    assign IF_PC_plus_4    = {IF_PC[31], IF_PC[30:0] + 31'd4};
    assign Flush_IF_and_ID = Branch_taken;

    assign redirect_code = (ID_PCSrc == 3'd2) || (ID_PCSrc == 3'd3) || (ID_PCSrc == 3'd5);
    assign take_irq      = irq_pending & ~IF_PC[31] & ~Stall & ~Branch_taken & ~redirect_code;

    always_comb begin
        next_pc = IF_PC_plus_4;
        bubble  = 1'b1;
        if (Branch_taken) begin
            next_pc = Branch_target;
        end else if (!Stall && ID_PCSrc == 3'd5) begin
            next_pc = EXC_VECTOR;
        end else if (!Stall && ID_PCSrc == 3'd2) begin
            next_pc = {IF_PC[31], Jump_target[30:0]};
        end else if (!Stall && ID_PCSrc == 3'd3) begin
            // A JR can only stay in or leave kernel mode, never enter it.
            next_pc = {Jr_target[31] & IF_PC[31], Jr_target[30:0]};
        end else if (take_irq) begin
            next_pc = IRQ_VECTOR;
        end else begin
            bubble  = 1'b0;
            next_pc = Stall ? IF_PC : IF_PC_plus_4;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            IF_PC          <= RESET_PC;
            ID_Instruction <= 32'd0;
            ID_PC_plus_4   <= RESET_PC;
            IRQ_Taken      <= 1'b0;
            EPC            <= 32'd0;
            irq_q          <= 1'b0;
            irq_pending    <= 1'b0;
        end else begin
            irq_q       <= IRQ;
            irq_pending <= (IRQ & ~irq_q) | (irq_pending & ~take_irq);
            IRQ_Taken   <= take_irq;
            if (take_irq) begin
                EPC <= IF_PC;
            end
            IF_PC <= next_pc;
            if (bubble) begin
                ID_Instruction <= 32'd0;
                ID_PC_plus_4   <= IF_PC_plus_4;
            end else if (!Stall) begin
                ID_Instruction <= IF_Instruction;
                ID_PC_plus_4   <= IF_PC_plus_4;
            end
        end
    end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios with literal expectations plus randomized traffic against a reference model.
module tb_if_stage;

    localparam logic [31:0] RESET_PC   = 32'h80000000;
    localparam logic [31:0] IRQ_VECTOR = 32'h80000004;
    localparam logic [31:0] EXC_VECTOR = 32'h80000008;

    logic        clk = 1'b0;
    logic        reset;
    logic        Stall;
    logic        Branch_taken;
    logic [31:0] Branch_target;
    logic [2:0]  ID_PCSrc;
    logic [31:0] Jump_target;
    logic [31:0] Jr_target;
    logic        IRQ;
    logic [31:0] IF_Instruction;
    logic [31:0] IF_PC;
    logic [31:0] IF_PC_plus_4;
    logic [31:0] ID_Instruction;
    logic [31:0] ID_PC_plus_4;
    logic        Flush_IF_and_ID;
    logic        IRQ_Taken;
    logic [31:0] EPC;

    if_stage #(.RESET_PC(RESET_PC), .IRQ_VECTOR(IRQ_VECTOR), .EXC_VECTOR(EXC_VECTOR)) dut (
        .clk(clk), .reset(reset), .Stall(Stall), .Branch_taken(Branch_taken),
        .Branch_target(Branch_target), .ID_PCSrc(ID_PCSrc), .Jump_target(Jump_target),
        .Jr_target(Jr_target), .IRQ(IRQ), .IF_Instruction(IF_Instruction),
        .IF_PC(IF_PC), .IF_PC_plus_4(IF_PC_plus_4), .ID_Instruction(ID_Instruction),
        .ID_PC_plus_4(ID_PC_plus_4), .Flush_IF_and_ID(Flush_IF_and_ID),
        .IRQ_Taken(IRQ_Taken), .EPC(EPC)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: architectural view of the stage.
    logic [31:0] m_pc, m_idi, m_idp, m_epc;
    logic        m_taken, m_prev_irq, m_pend;
    logic [31:0] n_pc, n_idi, n_idp, n_epc;
    logic        n_taken, n_prev_irq, n_pend;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = RESET_PC; m_idi = 32'd0; m_idp = RESET_PC; m_epc = 32'd0;
        m_taken = 1'b0; m_prev_irq = 1'b0; m_pend = 1'b0;
    endtask

    function automatic logic [31:0] seq(input logic [31:0] pc);
        return {pc[31], pc[30:0] + 31'd4};
    endfunction

    // Next state from the current model state and the inputs presently driven.
    task automatic model_next();
        logic redir, take;
        redir = ID_PCSrc inside {3'd2, 3'd3, 3'd5};
        take  = m_pend && !m_pc[31] && !Stall && !Branch_taken && !redir;
        n_epc = take ? m_pc : m_epc;
        n_taken = take;
        n_prev_irq = IRQ;
        n_pend = take ? 1'b0 : m_pend;
        if (IRQ && !m_prev_irq) n_pend = 1'b1;
        n_idi = 32'd0;
        n_idp = seq(m_pc);
        if (Branch_taken)                   n_pc = Branch_target;
        else if (!Stall && ID_PCSrc == 3'd5) n_pc = EXC_VECTOR;
        else if (!Stall && ID_PCSrc == 3'd2) n_pc = {m_pc[31], Jump_target[30:0]};
        else if (!Stall && ID_PCSrc == 3'd3) n_pc = {m_pc[31] & Jr_target[31], Jr_target[30:0]};
        else if (take)                       n_pc = IRQ_VECTOR;
        else if (Stall) begin
            n_pc = m_pc; n_idi = m_idi; n_idp = m_idp;
        end else begin
            n_pc = seq(m_pc); n_idi = IF_Instruction;
        end
    endtask

    task automatic check_all();
        chk("IF_PC", IF_PC, m_pc);
        chk("IF_PC_plus_4", IF_PC_plus_4, seq(m_pc));
        chk("ID_Instruction", ID_Instruction, m_idi);
        chk("ID_PC_plus_4", ID_PC_plus_4, m_idp);
        chk("IRQ_Taken", {31'd0, IRQ_Taken}, {31'd0, m_taken});
        chk("EPC", EPC, m_epc);
        chk("Flush", {31'd0, Flush_IF_and_ID}, {31'd0, Branch_taken});
    endtask

    task automatic cycle();
        model_next();
        @(posedge clk);
        #1;
        m_pc = n_pc; m_idi = n_idi; m_idp = n_idp; m_epc = n_epc;
        m_taken = n_taken; m_prev_irq = n_prev_irq; m_pend = n_pend;
        check_all();
    endtask

    task automatic idle();
        Stall = 0; Branch_taken = 0; ID_PCSrc = 3'd0;
    endtask

    task automatic go_to(input logic [31:0] target);
        Branch_taken = 1; Branch_target = target;
        cycle();
        Branch_taken = 0;
    endtask

    initial begin
        reset = 0; Stall = 0; Branch_taken = 0; Branch_target = 0; ID_PCSrc = 0;
        Jump_target = 0; Jr_target = 0; IRQ = 0; IF_Instruction = 32'h20080001;
        model_reset();
        #12;
        check_all();
        chk("reset IF_PC", IF_PC, 32'h80000000);
        chk("reset ID_PC_plus_4", ID_PC_plus_4, 32'h80000000);
        @(negedge clk);
        reset = 1;

        // Straight-line fetch from the reset vector.
        repeat (3) cycle();
        chk("seq3 IF_PC", IF_PC, 32'h8000000C);
        chk("seq3 ID_Instruction", ID_Instruction, 32'h20080001);
        chk("seq3 ID_PC_plus_4", ID_PC_plus_4, 32'h8000000C);

        // Stall holds everything and masks a decode jump.
        go_to(32'h0040000C);
        cycle();
        chk("pre-stall IF_PC", IF_PC, 32'h00400010);
        Stall = 1; ID_PCSrc = 3'd2; Jump_target = 32'h00123450;
        cycle();
        cycle();
        chk("stall IF_PC", IF_PC, 32'h00400010);
        chk("stall ID_Instruction", ID_Instruction, 32'h20080001);
        chk("stall ID_PC_plus_4", ID_PC_plus_4, 32'h00400010);
        idle();
        cycle();
        chk("post-stall IF_PC", IF_PC, 32'h00400014);

        // Branch overrides stall and decode jump.
        Stall = 1; ID_PCSrc = 3'd2; Branch_taken = 1; Branch_target = 32'h00400100;
        #1;
        chk("Flush on branch", {31'd0, Flush_IF_and_ID}, 32'd1);
        cycle();
        idle();
        chk("branch IF_PC", IF_PC, 32'h00400100);
        chk("branch ID_Instruction", ID_Instruction, 32'd0);

        // User-mode interrupt entry.
        IRQ = 1;
        go_to(32'h00400020);
        chk("irq user IF_PC", IF_PC, 32'h00400020);
        cycle();
        chk("irq entry IF_PC", IF_PC, 32'h80000004);
        chk("irq entry EPC", EPC, 32'h00400020);
        chk("irq entry ID_Instruction", ID_Instruction, 32'd0);
        chk("irq taken pulse", {31'd0, IRQ_Taken}, 32'd1);
        cycle();
        chk("irq taken cleared", {31'd0, IRQ_Taken}, 32'd0);

        // Interrupt raised in kernel waits for return to user.
        IRQ = 0;
        cycle();
        IRQ = 1;
        go_to(32'h80000050);
        repeat (3) cycle();
        chk("kernel no take", {31'd0, IRQ_Taken}, 32'd0);
        chk("kernel IF_PC", IF_PC, 32'h8000005C);
        ID_PCSrc = 3'd3; Jr_target = 32'h00400024;
        cycle();
        idle();
        chk("jr to user IF_PC", IF_PC, 32'h00400024);
        cycle();
        chk("deferred irq IF_PC", IF_PC, 32'h80000004);
        chk("deferred irq EPC", EPC, 32'h00400024);
        IRQ = 0;

        // User JR cannot enter kernel; exception vector.
        go_to(32'h00400000);
        ID_PCSrc = 3'd3; Jr_target = 32'h80001000;
        cycle();
        chk("user jr masked", IF_PC, 32'h00001000);
        idle();
        go_to(32'h00400000);
        ID_PCSrc = 3'd5;
        cycle();
        chk("exception IF_PC", IF_PC, 32'h80000008);
        idle();

        // Sequential wrap preserves bit 31.
        go_to(32'h7FFFFFFC);
        cycle();
        chk("user wrap", IF_PC, 32'h00000000);
        go_to(32'hFFFFFFFC);
        cycle();
        chk("kernel wrap", IF_PC, 32'h80000000);

        // Asynchronous reset while stalled with an interrupt pending.
        go_to(32'h00400200);
        IRQ = 1; Stall = 1;
        cycle();
        cycle();
        reset = 0;
        #1;
        model_reset();
        check_all();
        chk("mid reset IF_PC", IF_PC, 32'h80000000);
        @(negedge clk);
        reset = 1; idle(); IRQ = 0;
        go_to(32'h00400300);
        repeat (2) cycle();
        chk("pending lost by reset", {31'd0, IRQ_Taken}, 32'd0);

        // Randomized traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            Stall = ($urandom_range(0, 3) == 0);
            Branch_taken = ($urandom_range(0, 9) == 0);
            r = $urandom();
            Branch_target = {($urandom_range(0, 3) == 0), r[30:2], 2'b00};
            ID_PCSrc = ($urandom_range(0, 2) == 0) ? 3'($urandom_range(0, 7)) : 3'd0;
            Jump_target = $urandom();
            Jr_target = $urandom();
            IF_Instruction = $urandom();
            if ($urandom_range(0, 7) == 0) IRQ = ~IRQ;
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline latch; feeds the ID/EX register directly.
- Owns the PC, next-PC selection, redirect flushing and external-interrupt entry.
- Supplies IF_PC and IF_PC_plus_4 to the fetch path and to ID/EX, and ID_Instruction and ID_PC_plus_4 to decode.
- Bit 31 of the PC is the kernel-mode flag.

Parameters:
RESET_PC, 32'h80000000, PC value loaded on reset
IRQ_VECTOR, 32'h80000004, interrupt entry address
EXC_VECTOR, 32'h80000008, exception entry address (ID_PCSrc=5)

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset
Stall  input  1  load-use stall from hazard unit; hold PC and IF/ID
Branch_taken  input  1  branch in EX resolved taken
Branch_target  input  32  EX branch destination
ID_PCSrc  input  3  decode redirect: 0 none, 2 jump, 3 jr, 5 exception; other codes = none
Jump_target  input  32  J/JAL destination from ID
Jr_target  input  32  register value for JR/JALR from ID
IRQ  input  1  level interrupt request, asynchronous to program flow
IF_Instruction  input  32  instruction memory read data at IF_PC (combinational)
IF_PC  output  32  current fetch PC (register)
IF_PC_plus_4  output  32  {IF_PC[31], IF_PC[30:0]+4}, combinational
ID_Instruction  output  32  IF/ID instruction register
ID_PC_plus_4  output  32  IF/ID PC+4 register
Flush_IF_and_ID  output  1  combinational, equals Branch_taken
IRQ_Taken  output  1  registered one-cycle pulse, cycle after interrupt entry
EPC  output  32  registered return address of last taken interrupt

Behaviour:
- Reset (reset=0, async):
  - IF_PC=RESET_PC, ID_Instruction=0, ID_PC_plus_4=RESET_PC.
  - IRQ_Taken=0, EPC=0.
  - Internal irq_q=0, irq_pending=0.
- Interrupt tracking:
  - irq_q <= IRQ every cycle.
  - irq_pending is set on IRQ & ~irq_q (rising edge) and cleared on take.
  - If a set and a clear occur in the same cycle, set wins.
- take_irq = irq_pending & ~IF_PC[31] & ~Stall & ~Branch_taken & (ID_PCSrc not in {2,3,5}).
- Next-PC priority, highest first:
  1. Branch_taken -> Branch_target. Acts regardless of Stall.
  2. ~Stall & ID_PCSrc=5 -> EXC_VECTOR.
  3. ~Stall & ID_PCSrc=2 -> {IF_PC[31], Jump_target[30:0]}.
  4. ~Stall & ID_PCSrc=3 -> {Jr_target[31] & IF_PC[31], Jr_target[30:0]}. User code cannot enter kernel via JR.
  5. take_irq -> IRQ_VECTOR.
  6. Stall -> hold IF_PC.
  7. Otherwise -> IF_PC_plus_4. Wraps modulo 2^31 in bits 30:0; bit 31 is preserved.
- IF/ID latch update:
  - Bubble load (ID_Instruction<=0, ID_PC_plus_4<=IF_PC_plus_4) on cases 1–5.
  - No delay slot: the wrong-path fetch is discarded.
  - Hold on case 6.
  - Otherwise load IF_Instruction and IF_PC_plus_4.
- ID_PCSrc is ignored while Stall=1: the held ID instruction re-presents its redirect after the stall releases.
- On take_irq: EPC <= IF_PC, the abandoned instruction's address, so return re-executes it. IRQ_Taken <= 1 for exactly one cycle.
- Interrupts are never taken while IF_PC[31]=1. A pending request waits until the PC returns to user space.
- Single-cycle redirect latency: the target appears on IF_PC on the edge after the redirect input is sampled.
- Reset asserted mid-stall or mid-redirect: all state goes to reset values immediately; the pending IRQ is lost.

Test Plan:
- Reset release, Stall=0, no redirects, IF_Instruction=32'h20080001:
  - After 3 edges: IF_PC=32'h8000000C.
  - ID_Instruction=32'h20080001, ID_PC_plus_4=32'h8000000C.
- Stall=1 for 2 cycles at IF_PC=32'h00400010:
  - IF_PC and the IF/ID latch hold unchanged.
  - ID_PCSrc=2 during the stall is ignored.
  - After release: IF_PC=32'h00400014.
- Branch_taken=1, Branch_target=32'h00400100, same cycle as Stall=1 and ID_PCSrc=2:
  - Flush_IF_and_ID=1.
  - Next IF_PC=32'h00400100, ID_Instruction=0.
- IRQ rises at IF_PC=32'h00400020 (user mode):
  - Next edge: IF_PC=32'h80000004, EPC=32'h00400020, ID_Instruction=0.
  - IRQ_Taken=1 for one cycle only.
- IRQ rises while IF_PC=32'h80000050 (kernel); later ID_PCSrc=3 with Jr_target=32'h00400024:
  - No take while in kernel.
  - IF_PC becomes 32'h00400024, then the next edge enters 32'h80000004 with EPC=32'h00400024.
- User-mode jr with Jr_target=32'h80001000 at IF_PC=32'h00400000:
  - Next IF_PC=32'h00001000 (bit 31 masked).
  - ID_PCSrc=5 instead -> IF_PC=32'h80000008.
